// File: rtl/whack_pkg.sv
// Shared types and helpers for the score display path: glyph table, converter states, blank code.
package whack_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {CV_IDLE, CV_CONV, CV_DONE} conv_state_t;

    // Active-low a..g on bits 0..6
    function automatic logic [6:0] seg7_digit(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per cycle.
module bin2bcd_seq
    import whack_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state_q, state_d;
    logic [19:0] sh_q, sh_d;
    logic [2:0]  iter_q, iter_d;
    logic        busy_q, busy_d;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] a;
        a = s;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5)
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CV_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
        sh_q   <= sh_d;
        iter_q <= iter_d;
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        case (state_q)
            CV_IDLE: begin
                if (start) begin
                    sh_d    = {12'b0, bin};
                    iter_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = CV_CONV;
                end
            end
            CV_CONV: begin
                sh_d   = dabble_step(sh_q);
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7)
                    state_d = CV_DONE;
            end
            CV_DONE: begin
                busy_d  = 1'b0;
                state_d = CV_IDLE;
            end
            default: state_d = CV_IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = (state_q == CV_DONE);
    assign bcd  = sh_q[19:8];

endmodule

// File: rtl/score_bcd_mux.sv
// Score readout: BCD conversion on source change plus 3-digit multiplexed 7-segment drive.
// Optional HIGH_SCORE_EN adds a high-score register selectable by hi_sel.
module score_bcd_mux
    import whack_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  score,
    input  logic        game_end,
    input  logic        hi_sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_en,
    output logic [11:0] bcd_out,
    output logic        busy
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [7:0]       src, conv_src_q;
    logic             start, conv_busy, conv_done;
    logic [11:0]      conv_bcd, bcd_out_q;
    logic [CNT_W-1:0] scan_cnt_q;
    logic [1:0]       digit_idx_q;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       en_q, en_d;
    logic             dp_q, dp_d;
    logic [3:0]       nib;
    logic             blank;

`ifdef HIGH_SCORE_EN
    logic [7:0] hi_score_q;
    logic       game_end_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_score_q <= 8'd0;
            game_end_q <= 1'b0;
        end else begin
            game_end_q <= game_end;
            if (game_end && !game_end_q && (score > hi_score_q))
                hi_score_q <= score;
        end
    end

    assign src  = hi_sel ? hi_score_q : score;
    assign dp_d = !((digit_idx_q == 2'd0) && hi_sel);
`else
    logic in_unused;
    assign in_unused = ^{hi_sel, game_end};
    assign src  = score;
    assign dp_d = 1'b1;
`endif

    // Converter is idle exactly when busy is low; changes seen mid-conversion wait for the next idle
    assign start = !conv_busy && (src != conv_src_q);

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (src),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        case (digit_idx_q)
            2'd1:    nib = bcd_out_q[7:4];
            2'd2:    nib = bcd_out_q[11:8];
            default: nib = bcd_out_q[3:0];
        endcase
        blank = (BLANK_LZ != 0) &&
                (((digit_idx_q == 2'd2) && (bcd_out_q[11:8] == 4'd0)) ||
                 ((digit_idx_q == 2'd1) && (bcd_out_q[11:4] == 8'd0)));
        seg_d = blank ? SEG_BLANK : seg7_digit(nib);
        en_d  = blank ? 3'b111 : ~(3'b001 << digit_idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_src_q  <= 8'd0;
            bcd_out_q   <= 12'd0;
            scan_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            seg_q       <= SEG_BLANK;
            en_q        <= 3'b111;
            dp_q        <= 1'b1;
        end else begin
            if (start)
                conv_src_q <= src;
            if (conv_done)
                bcd_out_q <= conv_bcd;
            if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                scan_cnt_q  <= '0;
                digit_idx_q <= (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
            seg_q <= seg_d;
            en_q  <= en_d;
            dp_q  <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign digit_en = en_q;
    assign bcd_out  = bcd_out_q;
    assign busy     = conv_busy;

endmodule

// File: tb/tb_score_bcd_mux.sv
// Directed bench for score_bcd_mux with an arithmetic reference model compared every cycle.
module tb_score_bcd_mux;

    localparam int SCAN_DIV = 4;
    localparam int BLANK_LZ = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  score = 8'd0;
    logic        game_end = 1'b0;
    logic        hi_sel = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_en;
    logic [11:0] bcd_out;
    logic        busy;

    always #5 clk = ~clk;

    score_bcd_mux #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .game_end (game_end),
        .hi_sel   (hi_sel),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en),
        .bcd_out  (bcd_out),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [6:0] GLY [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Reference model: value shown = last source value, settled 9 cycles after it was taken
    int m_val = 0, m_src = 0, m_cnt = 0, m_hi = 0, m_scan = 0, m_idx = 0;
    bit m_ge = 1'b0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [2:0]  e_en = 3'b111;
    logic [11:0] e_bcd = 12'd0;
    logic        e_busy = 1'b0;

    always @(posedge clk) begin
        int h, t, o, d, s;
        bit blank;
        if (rst) begin
            m_val = 0; m_src = 0; m_cnt = 0; m_hi = 0; m_scan = 0; m_idx = 0; m_ge = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_en = 3'b111; e_bcd = 12'd0; e_busy = 1'b0;
        end else begin
            h = m_val / 100;
            t = (m_val / 10) % 10;
            o = m_val % 10;
            d = (m_idx == 0) ? o : (m_idx == 1) ? t : h;
            blank = (BLANK_LZ != 0) && ((m_idx == 2 && h == 0) || (m_idx == 1 && h == 0 && t == 0));
            e_seg = blank ? 7'h7F : GLY[d];
            e_en  = blank ? 3'b111 : ~(3'b001 << m_idx);
`ifdef HIGH_SCORE_EN
            e_dp = !(m_idx == 0 && hi_sel);
            s = hi_sel ? m_hi : int'(score);
`else
            e_dp = 1'b1;
            s = int'(score);
`endif
            if (m_cnt == 0) begin
                if (s != m_src) begin
                    m_src = s;
                    m_cnt = 9;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_val = m_src;
            end
            e_busy = (m_cnt != 0);
            e_bcd  = to_bcd(m_val);
`ifdef HIGH_SCORE_EN
            if (game_end && !m_ge && int'(score) > m_hi) m_hi = int'(score);
            m_ge = game_end;
`endif
            if (m_scan == SCAN_DIV - 1) begin
                m_scan = 0;
                m_idx = (m_idx + 1) % 3;
            end else begin
                m_scan++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_seg", seg, e_seg);
            chk("m_dp", dp, e_dp);
            chk("m_digit_en", digit_en, e_en);
            chk("m_bcd_out", bcd_out, e_bcd);
            chk("m_busy", busy, e_busy);
        end
    end

    task automatic conv_wait(input logic [7:0] v, output int bc, output int upd);
        logic [11:0] prev;
        prev = bcd_out;
        bc = 0;
        upd = 0;
        score = v;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (upd == 0 && bcd_out !== prev) upd = k;
        end
    endtask

    task automatic scan_check(input string tag, input logic [6:0] x0, input logic [6:0] x1,
                              input logic [6:0] x2);
        logic [6:0] g0, g1, g2;
        g0 = 7'h7F; g1 = 7'h7F; g2 = 7'h7F;
        repeat (12) begin
            @(negedge clk);
            case (digit_en)
                3'b110:  g0 = seg;
                3'b101:  g1 = seg;
                3'b011:  g2 = seg;
                3'b111:  chk({tag, "_blank_seg"}, seg, 7'h7F);
                default: chk({tag, "_en_legal"}, digit_en, 3'b111);
            endcase
        end
        chk({tag, "_ones"}, g0, x0);
        chk({tag, "_tens"}, g1, x1);
        chk({tag, "_hund"}, g2, x2);
    endtask

    initial begin
        int bc, upd, seen;
        logic [11:0] prev;
        logic [11:0] q[$];

        // 1: reset, score 0
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            chk("t1_busy", busy, 1'b0);
            if (digit_en == 3'b110) begin
                seen++;
                chk("t1_seg0", seg, 7'h40);
            end else begin
                chk("t1_en_blank", digit_en, 3'b111);
            end
        end
        chk("t1_ones_cycles", seen, 4);
        chk("t1_bcd", bcd_out, 12'h000);

        // 2: 0 -> 255
        conv_wait(8'd255, bc, upd);
        chk("t2_busy_cycles", bc, 9);
        chk("t2_upd_edge", upd, 10);
        chk("t2_bcd", bcd_out, 12'h255);
        scan_check("t2", 7'b0010010, 7'b0010010, 7'b0100100);

        // 3: 37 then 142 mid-conversion
        prev = bcd_out;
        score = 8'd37;
        repeat (3) @(negedge clk);
        score = 8'd142;
        repeat (40) begin
            @(negedge clk);
            if (bcd_out !== prev) begin
                q.push_back(bcd_out);
                prev = bcd_out;
            end
        end
        chk("t3_nvals", q.size(), 2);
        if (q.size() >= 2) begin
            chk("t3_first", q[0], 12'h037);
            chk("t3_second", q[1], 12'h142);
        end

        // 4: inner zero kept, leading zeros blanked
        conv_wait(8'd105, bc, upd);
        chk("t4_bcd105", bcd_out, 12'h105);
        scan_check("t4a", 7'h12, 7'h40, 7'h79);
        conv_wait(8'd7, bc, upd);
        chk("t4_bcd7", bcd_out, 12'h007);
        scan_check("t4b", 7'h78, 7'h7F, 7'h7F);

`ifdef HIGH_SCORE_EN
        // 5: high score capture and display
        score = 8'd42;
        repeat (2) @(negedge clk);
        game_end = 1'b1;
        repeat (2) @(negedge clk);
        game_end = 1'b0;
        score = 8'd17;
        repeat (2) @(negedge clk);
        game_end = 1'b1;
        repeat (2) @(negedge clk);
        game_end = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_bcd17", bcd_out, 12'h017);
        hi_sel = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_hi42", bcd_out, 12'h042);
        scan_check("t5", 7'h24, 7'h19, 7'h7F);
        seen = 0;
        for (int k = 0; k < 6 && seen == 0; k++) begin
            @(negedge clk);
            if (digit_en == 3'b110) begin
                seen = 1;
                chk("t5_dp_ones", dp, 1'b0);
            end
        end
        chk("t5_dp_seen", seen, 1);
        hi_sel = 1'b0;
        repeat (15) @(negedge clk);
`endif

        // 6: reset during conversion of 200
        score = 8'd200;
        repeat (5) @(negedge clk);
        chk("t6_busy_mid", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_seg", seg, 7'h7F);
        chk("t6_rst_dp", dp, 1'b1);
        chk("t6_rst_en", digit_en, 3'b111);
        chk("t6_rst_bcd", bcd_out, 12'h000);
        chk("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        conv_wait(8'd200, bc, upd);
        chk("t6_busy_cycles", bc, 9);
        chk("t6_upd_edge", upd, 10);
        chk("t6_bcd", bcd_out, 12'h200);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
